cache_arbiter: RTL and testbench

Shares one 128-bit line-granular physical memory port between the instruction cache and the data cache. It grants one requester at a time with two-way round-robin fairness and latches that requester's command. It then drives the memory read/write level handshake until `pmem_resp`, and routes the one-cycle response back to the granted cache. It sits between the two L1 caches and `physical_memory`.

---
 rtl/cache_arbiter_pkg.sv | 25 ++
 rtl/cache_arbiter_pick.sv | 23 ++
 rtl/cache_arbiter.sv | 110 +++++++++++
 tb/tb_cache_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the two-port L1 -> physical memory arbiter.
package arbiter_types;

  // Arbiter FSM: idle, or serving one latched command for I or D.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Requester identity, also used to remember the last grant.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // Byte offset bits within a 128-bit line.
  localparam int unsigned LINE_OFFSET_BITS = 4;

  // The requester that did not win last time.
  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/cache_arbiter_pick.sv
// Two-way round-robin selector; purely combinational.
module rr_pick2
  import arbiter_types::*;
(
  input  logic    req_i,
  input  logic    req_d,
  input  req_id_t last_grant,
  output logic    grant_valid,
  output req_id_t grant_id
);

  // A lone requester wins outright; a tie goes to whoever did not win last.
  always_comb begin
    grant_valid = req_i | req_d;
    grant_id    = REQ_I;
    if (req_i && req_d) begin
      grant_id = other_req(last_grant);
    end else if (req_d) begin
      grant_id = REQ_D;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one line-granular memory port between the I-cache and D-cache.
// One command is latched at grant and held until the memory responds.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);

  arb_state_t            state_q, state_d;
  req_id_t               last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;

  logic                  grant_valid;
  req_id_t               grant_id;

  rr_pick2 u_pick (
    .req_i       (i_read | i_write),
    .req_d       (d_read | d_write),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Next state: grant only from IDLE, so a completed requester gets an edge
  // to drop its level before it can be considered again.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant_id;
          if (grant_id == REQ_D) begin
            state_d = SERVE_D;
            addr_d  = d_address;
            wdata_d = d_wdata;
            write_d = d_write;
          end else begin
            state_d = SERVE_I;
            addr_d  = i_address;
            wdata_d = i_wdata;
            write_d = i_write;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and command latches; reset aborts any service in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
    end
  end

  // Memory request levels from the latch; responses steered by state only,
  // so a pmem_resp seen in IDLE reaches neither cache.
  always_comb begin
    pmem_read    = (state_q != IDLE) && !write_q;
    pmem_write   = (state_q != IDLE) && write_q;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    i_resp       = (state_q == SERVE_I) && pmem_resp;
    d_resp       = (state_q == SERVE_D) && pmem_resp;
    i_rdata      = pmem_rdata;
    d_rdata      = pmem_rdata;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboarded bench: a latency memory model plus two cache drivers.
module tb_cache_arbiter;

  localparam int unsigned AW  = 16;
  localparam int unsigned LW  = 128;
  localparam int unsigned LAT = 20;  // 200 ns at a 10 ns clock

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] i_wdata, d_wdata;
  logic          i_resp, d_resp;
  logic [LW-1:0] i_rdata, d_rdata;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;

  logic          mem_resp_q;
  logic          spur;
  int unsigned   mem_cnt;
  logic [LW-1:0] mem [logic [11:0]];

  typedef struct {
    bit            is_d;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_resp_cyc = 0;
  int n_wr_svc = 0;
  int n_rd_svc = 0;
  bit prev_active = 0;
  bit expect_b2b = 0;
  bit arm = 0;

  localparam logic [LW-1:0] DEADBEEF = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

  always #5 clk = ~clk;

  assign pmem_resp = mem_resp_q | spur;

  cache_arbiter #(
    .ADDR_WIDTH (AW),
    .LINE_WIDTH (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_address    (i_address),
    .i_wdata      (i_wdata),
    .i_resp       (i_resp),
    .i_rdata      (i_rdata),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_resp       (d_resp),
    .d_rdata      (d_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  function automatic logic [LW-1:0] init_line(input logic [11:0] idx);
    return {8{4'hA, idx}};
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Memory: respond LAT cycles after a request level appears, one-cycle pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt    <= 0;
      mem_resp_q <= 1'b0;
      pmem_rdata <= '0;
    end else begin
      mem_resp_q <= 1'b0;
      if ((pmem_read || pmem_write) && !mem_resp_q) begin
        if (mem_cnt == LAT - 1) begin
          mem_cnt    <= 0;
          mem_resp_q <= 1'b1;
          if (pmem_write) begin
            mem[pmem_address[15:4]] = pmem_wdata;
          end else begin
            pmem_rdata <= mem.exists(pmem_address[15:4]) ? mem[pmem_address[15:4]]
                                                         : init_line(pmem_address[15:4]);
          end
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end else begin
        mem_cnt <= 0;
      end
    end
  end

  // Monitor: pop the scoreboard on every resp and check service ordering.
  always @(negedge clk) begin
    bit   active;
    exp_t e;
    cyc++;
    if (!expect_b2b) arm = 0;
    if (rst_n) begin
      active = pmem_read | pmem_write;
      if (active && !prev_active) begin
        if (pmem_write) n_wr_svc++;
        else n_rd_svc++;
        if (arm) begin
          check("b2b_gap", cyc - last_resp_cyc, 2);
          arm = 0;
        end
      end
      if (i_resp || d_resp) begin
        check("resp_onehot", i_resp & d_resp, 0);
        check("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("resp_id", d_resp, e.is_d);
          check("resp_addr", pmem_address, e.addr);
          check("resp_op", pmem_write, e.wr);
          if (!e.wr) check("resp_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
        end
        last_resp_cyc = cyc;
        if (expect_b2b) arm = 1;
      end
      prev_active = active;
    end else begin
      prev_active = 0;
    end
  end

  // Cache driver: raise a level, hold until resp, drop it on the next edge.
  task automatic do_req(input bit is_d, input bit wr, input logic [AW-1:0] a,
                        input logic [LW-1:0] wd);
    bit got = 0;
    @(negedge clk);
    if (is_d) begin
      d_read = !wr; d_write = wr; d_address = a; d_wdata = wd;
    end else begin
      i_read = !wr; i_write = wr; i_address = a; i_wdata = wd;
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((is_d ? d_resp : i_resp) === 1'b1) begin
        got = 1;
        break;
      end
    end
    check(is_d ? "d_done" : "i_done", got, 1);
    @(posedge clk);
    #1;
    if (is_d) begin
      d_read = 0; d_write = 0;
    end else begin
      i_read = 0; i_write = 0;
    end
  endtask

  function automatic exp_t mk(input bit is_d, input bit wr, input logic [AW-1:0] a,
                              input logic [LW-1:0] rd);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = a; e.rdata = rd;
    return e;
  endfunction

  task automatic tie(input bit d_first);
    @(posedge clk);
    #1;
    expect_b2b = 1;
    if (d_first) begin
      sb_q.push_back(mk(1, 0, 16'h0700, init_line(12'h070)));
      sb_q.push_back(mk(0, 0, 16'h0800, init_line(12'h080)));
    end else begin
      sb_q.push_back(mk(0, 0, 16'h0800, init_line(12'h080)));
      sb_q.push_back(mk(1, 0, 16'h0700, init_line(12'h070)));
    end
    fork
      do_req(1, 0, 16'h0700, '0);
      do_req(0, 0, 16'h0800, '0);
    join
    @(posedge clk);
    #1;
    expect_b2b = 0;
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, rd0;
    i_read = 0; i_write = 0; i_address = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    spur = 0;
    rst_n = 0;
    #1;
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_i_resp", i_resp, 0);
    check("rst_d_resp", d_resp, 0);
    check("rst_addr", pmem_address, 0);
    check("rst_wdata", pmem_wdata, 0);
    #22 rst_n = 1;
    repeat (2) @(negedge clk);

    // First tie after reset goes to D.
    tie(1);

    // I-cache only read.
    sb_q.push_back(mk(0, 0, 16'h0120, init_line(12'h012)));
    fork
      do_req(0, 0, 16'h0120, '0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("grant_rd", pmem_read, 1);
        check("grant_wr", pmem_write, 0);
        check("grant_addr", pmem_address, 16'h0120);
      end
    join

    // D write then read back.
    wr0 = n_wr_svc;
    rd0 = n_rd_svc;
    sb_q.push_back(mk(1, 1, 16'h0450, '0));
    do_req(1, 1, 16'h0450, DEADBEEF);
    sb_q.push_back(mk(1, 0, 16'h0450, DEADBEEF));
    do_req(1, 0, 16'h0450, '0);
    check("wr_svc_count", n_wr_svc - wr0, 1);
    check("rd_svc_count", n_rd_svc - rd0, 1);

    // Last grant was D, so this tie goes to I.
    tie(0);

    // Address change mid-service is ignored.
    sb_q.push_back(mk(0, 0, 16'h0100, init_line(12'h010)));
    fork
      do_req(0, 0, 16'h0100, '0);
      begin
        repeat (5) @(negedge clk);
        i_address = 16'h0200;
        @(negedge clk);
        check("hold_addr", pmem_address, 16'h0100);
      end
    join

    // Spurious resp in IDLE.
    repeat (2) @(negedge clk);
    spur = 1;
    #1;
    check("spur_i_resp", i_resp, 0);
    check("spur_d_resp", d_resp, 0);
    @(posedge clk);
    #1;
    spur = 0;
    check("spur_idle_rd", pmem_read, 0);
    check("spur_idle_wr", pmem_write, 0);

    // Reset during SERVE_D: last_grant was I, so make D the last winner first.
    sb_q.push_back(mk(1, 0, 16'h0050, init_line(12'h005)));
    do_req(1, 0, 16'h0050, '0);
    @(negedge clk);
    d_read = 1; d_address = 16'h0300;
    repeat (4) @(negedge clk);
    check("mid_busy", pmem_read, 1);
    #2 rst_n = 0;
    #1;
    check("mid_rst_rd", pmem_read, 0);
    check("mid_rst_wr", pmem_write, 0);
    check("mid_rst_addr", pmem_address, 0);
    check("mid_rst_dresp", d_resp, 0);
    d_read = 0;
    @(negedge clk);
    #2 rst_n = 1;
    repeat (2) @(negedge clk);

    // last_grant back to I after reset, so D wins the tie.
    tie(1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
